res_arbiter: RTL and testbench



---
 rtl/res_arbiter.sv | 159 +++++++++++++++
 tb/tb_res_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_arbiter.sv
// res_arbiter: round-robin arbiter/sequencer sharing one transaction-based
// resource among REQ_COUNT requesters.
//
// Flow per transaction: IDLE (pick requester) -> START (one-cycle res_start)
// -> WAIT (until res_done) -> RELEASE (done pulse, pointer advance) -> IDLE.
//
// Optional feature: define ARB_TIMEOUT_EN to build the WAIT watchdog. The
// watchdog forces RELEASE with err/res_abort after TIMEOUT WAIT cycles.
// Without it, err and res_abort are tied low and WAIT is unbounded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[i]            level request, held until done[i]
//   wdata             requester i's word at [i*word_width +: word_width]
//   gnt               one-hot grant, zero when idle
//   done              one-cycle completion pulse to the granted requester
//   err               high with done when the transaction timed out
//   rdata             read word, updated in the done cycle, then held
//   res_start         one-cycle start strobe to the resource
//   res_wdata         latched write word, stable from START through RELEASE
//   res_abort         one-cycle abort strobe on timeout
//   res_done          resource completion, only honoured in WAIT
//   res_rdata         resource result, sampled with res_done
module res_arbiter #(
  parameter int REQ_COUNT  = 4,
  parameter int word_width = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_COUNT-1:0]            req,
  input  logic [REQ_COUNT*word_width-1:0] wdata,
  output logic [REQ_COUNT-1:0]            gnt,
  output logic [REQ_COUNT-1:0]            done,
  output logic                            err,
  output logic [word_width-1:0]           rdata,
  output logic                            res_start,
  output logic [word_width-1:0]           res_wdata,
  output logic                            res_abort,
  input  logic                            res_done,
  input  logic [word_width-1:0]           res_rdata
);

  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(REQ_COUNT - 1);

  if (REQ_COUNT < 2 || TIMEOUT < 2) begin : g_param_chk
    $error("res_arbiter: REQ_COUNT and TIMEOUT must both be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

  state_t  state;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr;

  // Per-requester view of the flat write bus.
  logic [REQ_COUNT-1:0][word_width-1:0] wd_lane;
  assign wd_lane = wdata;

  // Rotating priority: first set request at or above ptr, wrapping to 0.
  // Scanning from the far end downward lets the nearest candidate win.
  logic [IW-1:0] nxt;
  logic [IW-1:0] cand;
  always_comb begin
    nxt  = ptr;
    cand = '0;
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % REQ_COUNT);
      if (req[cand]) nxt = cand;
    end
  end

  logic [REQ_COUNT-1:0] nxt_oh;
  logic [REQ_COUNT-1:0] idx_oh;
  for (genvar i = 0; i < REQ_COUNT; i++) begin : g_lane
    assign nxt_oh[i] = (nxt == IW'(i));
    assign idx_oh[i] = (idx == IW'(i));
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wd_cnt;
`else
  assign err       = 1'b0;
  assign res_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      res_start <= 1'b0;
      res_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 1'b0;
      res_abort <= 1'b0;
`endif
    end else begin
      // Strobes default low; each is raised for exactly one state.
      res_start <= 1'b0;
      done      <= '0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
      res_abort <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req) begin
            idx       <= nxt;
            gnt       <= nxt_oh;
            res_wdata <= wd_lane[nxt];
            res_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // res_done wins over a watchdog expiry in the same cycle.
          if (res_done) begin
            rdata <= res_rdata;
            gnt   <= '0;
            done  <= idx_oh;
            state <= S_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == CNT_LAST) begin
            rdata     <= '0;
            gnt       <= '0;
            done      <= idx_oh;
            err       <= 1'b1;
            res_abort <= 1'b1;
            state     <= S_RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          ptr   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_arbiter.sv
module tb_res_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic [W-1:0]    rdata;
  logic            res_start;
  logic [W-1:0]    res_wdata;
  logic            res_abort;
  logic            res_done;
  logic [W-1:0]    res_rdata;

  res_arbiter #(.REQ_COUNT(N), .word_width(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .res_start(res_start), .res_wdata(res_wdata),
    .res_abort(res_abort), .res_done(res_done), .res_rdata(res_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    int             lat;      // res_done asserted lat cycles after START
    logic [W-1:0]   rsp;
    logic [N-1:0]   exp_gnt;
    logic [W-1:0]   exp_wd;
  } vec_t;

  vec_t tbl [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1 << i);
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, " gnt"}, gnt, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " err"}, err, 0);
    chk({nm, " rdata"}, rdata, 0);
    chk({nm, " start"}, res_start, 0);
    chk({nm, " wdata"}, res_wdata, 0);
    chk({nm, " abort"}, res_abort, 0);
  endtask

  // One table row: request from IDLE, complete after r.lat WAIT cycles.
  task automatic run_row(input vec_t r, input int row);
    string tag;
    tag = $sformatf("tbl%0d", row);
    req = r.req; wdata = r.wdata; res_done = 1'b0;
    tick;  // START
    chk({tag, " gnt"}, gnt, r.exp_gnt);
    chk({tag, " start"}, res_start, 1);
    chk({tag, " wdata"}, res_wdata, r.exp_wd);
    for (int k = 1; k <= r.lat; k++) begin
      tick;  // WAIT cycle k
      chk({tag, " hold"}, gnt, r.exp_gnt);
      chk({tag, " start off"}, res_start, 0);
      chk({tag, " early done"}, done, 0);
      if (k == r.lat) begin res_done = 1'b1; res_rdata = r.rsp; end
    end
    tick;  // RELEASE
    res_done = 1'b0; res_rdata = 8'($urandom);
    chk({tag, " done"}, done, r.exp_gnt);
    chk({tag, " rdata"}, rdata, r.rsp);
    chk({tag, " gnt off"}, gnt, 0);
    chk({tag, " wdata held"}, res_wdata, r.exp_wd);
    chk({tag, " err"}, err, 0);
    req = '0;
    tick;  // IDLE
    chk({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int order [5];
    int seen, last, s;
    bit prev_start;
    bit busy;
    int start_c, done_c, lat, mptr, g;
    logic [N-1:0] mg, rq;
    logic [W-1:0] m_wd, m_rd, wd_pend, plan;

    // {req, wdata, lat, rsp, expected grant, expected write word}; ptr starts at 0.
    tbl[0] = '{4'b0100, 32'h11A5_2233, 3, 8'h3C, 4'b0100, 8'hA5};
    tbl[1] = '{4'b0010, 32'h4455_6677, 1, 8'h81, 4'b0010, 8'h66};
    tbl[2] = '{4'b1001, 32'h9A00_00BC, 2, 8'h5E, 4'b1000, 8'h9A};
    tbl[3] = '{4'b1001, 32'hDE00_00F0, 1, 8'h12, 4'b0001, 8'hF0};
    tbl[4] = '{4'b0001, 32'h0000_00C3, 4, 8'hFF, 4'b0001, 8'hC3};
    tbl[5] = '{4'b1110, 32'h1234_5678, 2, 8'h01, 4'b0010, 8'h56};
    tbl[6] = '{4'b0011, 32'hAABB_CCDD, 1, 8'h80, 4'b0001, 8'hDD};
    tbl[7] = '{4'b1100, 32'h0102_0304, 3, 8'h7E, 4'b0100, 8'h02};
    tbl[8] = '{4'b0111, 32'hF0E1_D2C3, 2, 8'h44, 4'b0001, 8'hC3};

    // Reset with random inputs for two cycles.
    rst = 1'b1; req = N'($urandom); wdata = $urandom;
    res_done = 1'b1; res_rdata = 8'($urandom);
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0; req = '0; res_done = 1'b0;
    tick; tick;
    chk("idle gnt", gnt, 0);
    chk("idle start", res_start, 0);

    foreach (tbl[i]) run_row(tbl[i], i);

    // Fairness: all requesting, resource done one cycle after start.
    rst = 1'b1; tick; rst = 1'b0;
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111; seen = 0; last = -1; prev_start = 1'b0;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      tick;
      res_done = prev_start; res_rdata = 8'(c);
      prev_start = res_start;
      if (res_start) begin
        chk($sformatf("fair gnt%0d", seen), gnt, oh(order[seen]));
        if (seen > 0) chk($sformatf("fair gap%0d", seen), c - last, 4);
        last = c;
        seen++;
      end
    end
    chk("fair count", seen, 5);
    req = '0;
    tick; res_done = 1'b1; res_rdata = 8'h99;
    tick; res_done = 1'b0;
    chk("fair last done", done, 4'b0001);
    tick;

    // Reset in the second WAIT cycle (ptr is 1, so requester 2 wins).
    req = 4'b0100; wdata = 32'h00AB_0000;
    tick; chk("rstw gnt", gnt, 4'b0100);
    tick; tick; rst = 1'b1;
    tick; rst = 1'b0;
    chk_all_zero("rstw");
    req = 4'b0001; wdata = 32'h0000_0033;
    tick;
    chk("rstw regnt", gnt, 4'b0001);
    chk("rstw restart", res_start, 1);
    chk("rstw nodone", done, 0);
    tick; res_done = 1'b1; res_rdata = 8'h77;
    tick; res_done = 1'b0;
    chk("rstw done", done, 4'b0001);
    chk("rstw rdata", rdata, 8'h77);
    req = '0;
    tick;

    // Resource that never answers (ptr is 1, so requester 1 wins).
`ifdef ARB_TIMEOUT_EN
    req = 4'b0110;
    tick; chk("to gnt", gnt, 4'b0010);  // cycle s
    for (int k = 1; k <= TO; k++) begin
      tick;
      chk("to hold", gnt, 4'b0010);
      chk("to early done", done, 0);
    end
    tick;  // s+TO+1
    chk("to done", done, 4'b0010);
    chk("to err", err, 1);
    chk("to abort", res_abort, 1);
    chk("to rdata", rdata, 0);
    chk("to gnt off", gnt, 0);
    req = 4'b0100;
    tick;
    chk("to err pulse", {err, res_abort}, 0);
    chk("to done pulse", done, 0);
    tick;
    chk("to next gnt", gnt, 4'b0100);
    chk("to next start", res_start, 1);
    tick; res_done = 1'b1; res_rdata = 8'h55;
    tick; res_done = 1'b0;
    chk("to next done", done, 4'b0100);
    chk("to next err", err, 0);
    chk("to next rdata", rdata, 8'h55);
    req = '0;
    tick;
`else
    req = 4'b0010;
    tick; chk("hold gnt", gnt, 4'b0010);
    for (int k = 1; k <= 30; k++) begin
      tick;
      if (k % 10 == 0) begin
        chk("hold still", gnt, 4'b0010);
        chk("hold nodone", done, 0);
        chk("hold noerr", {err, res_abort}, 0);
      end
    end
    res_done = 1'b1; res_rdata = 8'h55;
    tick; res_done = 1'b0;
    chk("hold done", done, 4'b0010);
    chk("hold rdata", rdata, 8'h55);
    req = '0;
    tick;
`endif

    // Random traffic against a transaction-timeline model.
    rst = 1'b1; req = '0; res_done = 1'b0; tick; rst = 1'b0;
    busy = 1'b0; mptr = 0; m_wd = '0; m_rd = '0; rq = '0; mg = '0;
    start_c = -10; done_c = -10; lat = 1; plan = '0; wd_pend = '0;
    for (int n = 0; n < 600; n++) begin
      if (busy && n > done_c) busy = 1'b0;
      if (busy && n == start_c) m_wd = wd_pend;
      if (busy && n == done_c) m_rd = plan;
      chk("rnd gnt", gnt, (busy && n >= start_c && n < done_c) ? mg : '0);
      chk("rnd start", res_start, (busy && n == start_c) ? 1 : 0);
      chk("rnd done", done, (busy && n == done_c) ? mg : '0);
      chk("rnd rdata", rdata, m_rd);
      chk("rnd wdata", res_wdata, m_wd);
      chk("rnd err", {err, res_abort}, 0);
      for (int i = 0; i < N; i++) begin
        if (busy && mg[i] && n < done_c) begin
          if ($urandom % 4 == 0) rq[i] = 1'b0;
        end else if (busy && mg[i] && n == done_c) begin
          rq[i] = ($urandom % 2) == 1;
        end else if (!rq[i]) begin
          rq[i] = ($urandom % 3) == 0;
        end
      end
      req = rq; wdata = $urandom;
      if (busy && n == start_c + lat) begin
        res_done = 1'b1; res_rdata = plan;
      end else if (busy && n > start_c && n < start_c + lat) begin
        res_done = 1'b0; res_rdata = 8'($urandom);
      end else begin
        res_done = ($urandom % 3) == 0; res_rdata = 8'($urandom);
      end
      if (!busy && rq != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && rq[(mptr + k) % N]) g = (mptr + k) % N;
        busy = 1'b1; mg = oh(g);
        start_c = n + 1; lat = $urandom_range(1, 5); done_c = start_c + lat + 1;
        wd_pend = wdata[g*W +: W]; plan = 8'($urandom);
        mptr = (g + 1) % N;
      end
      tick;
    end

    s = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
